// File: rtl/result_display_sequencer_if.sv
// Handshake and display bus between the ALU result register, the
// display sequencer and the four 7-segment decoder instances.
interface result_display_sequencer_if #(
  parameter int WIDTH = 14
);
  logic             load;
  logic [WIDTH-1:0] value;
  logic             error;
  logic [4:0]       char3;
  logic [4:0]       char2;
  logic [4:0]       char1;
  logic [4:0]       char0;
  logic [3:0]       en;
  logic             busy;
  logic             done;

  modport master (
    output load, value, error,
    input  char3, char2, char1, char0, en, busy, done
  );

  modport slave (
    input  load, value, error,
    output char3, char2, char1, char0, en, busy, done
  );
endinterface

// File: rtl/result_display_sequencer.sv
// Turns a signed result into four 7-segment character codes, one
// power-of-ten subtraction per clock, with blanking, sign and Err/oF patterns.
module result_display_sequencer #(
  parameter int WIDTH = 14
) (
  input logic                       clk,
  input logic                       reset,
  result_display_sequencer_if.slave bus
);

  localparam int CW = WIDTH + 1;
  localparam logic signed [CW-1:0] MAX_VAL = CW'(9999);
  localparam logic signed [CW-1:0] MIN_VAL = CW'(-999);

  localparam logic [4:0] CH_F     = 5'd10;
  localparam logic [4:0] CH_MINUS = 5'd11;
  localparam logic [4:0] CH_O     = 5'd12;
  localparam logic [4:0] CH_R     = 5'd13;
  localparam logic [4:0] CH_E     = 5'd14;

  typedef enum logic [1:0] {IDLE, CHECK, SUB, FORMAT} state_t;

  state_t                 state_q, state_n;
  logic [WIDTH-1:0]       val_q, val_n;
  logic                   err_q, err_n;
  logic                   neg_q, neg_n;
  logic [WIDTH-1:0]       mag_q, mag_n;
  logic [3:0]             d3_q, d3_n, d2_q, d2_n, d1_q, d1_n;
  logic [1:0]             place_q, place_n;
  logic [4:0]             c3_q, c3_n, c2_q, c2_n, c1_q, c1_n, c0_q, c0_n;
  logic [3:0]             en_q, en_n;
  logic                   done_q, done_n;
  logic [1:0]             k;
  logic signed [CW-1:0]   val_ext;
  logic [WIDTH-1:0]       abs_val;

  assign val_ext = CW'($signed(val_q));
  assign abs_val = val_q[WIDTH-1] ? ((~val_q) + WIDTH'(1)) : val_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      val_q   <= '0;
      err_q   <= 1'b0;
      neg_q   <= 1'b0;
      mag_q   <= '0;
      d3_q    <= '0;
      d2_q    <= '0;
      d1_q    <= '0;
      place_q <= '0;
      c3_q    <= '0;
      c2_q    <= '0;
      c1_q    <= '0;
      c0_q    <= '0;
      en_q    <= 4'b0001;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      val_q   <= val_n;
      err_q   <= err_n;
      neg_q   <= neg_n;
      mag_q   <= mag_n;
      d3_q    <= d3_n;
      d2_q    <= d2_n;
      d1_q    <= d1_n;
      place_q <= place_n;
      c3_q    <= c3_n;
      c2_q    <= c2_n;
      c1_q    <= c1_n;
      c0_q    <= c0_n;
      en_q    <= en_n;
      done_q  <= done_n;
    end
  end

  // The final display is registered on the edge that enters FORMAT, so the
  // chars are valid in the same cycle done is high; FORMAT then acts as idle.
  always_comb begin
    state_n = state_q;
    val_n   = val_q;
    err_n   = err_q;
    neg_n   = neg_q;
    mag_n   = mag_q;
    d3_n    = d3_q;
    d2_n    = d2_q;
    d1_n    = d1_q;
    place_n = place_q;
    c3_n    = c3_q;
    c2_n    = c2_q;
    c1_n    = c1_q;
    c0_n    = c0_q;
    en_n    = en_q;
    done_n  = 1'b0;

    k = 2'd0;
    if (d1_q != 4'd0) k = 2'd1;
    if (d2_q != 4'd0) k = 2'd2;
    if (d3_q != 4'd0) k = 2'd3;

    case (state_q)
      IDLE, FORMAT: begin
        state_n = IDLE;
        if (bus.load) begin
          val_n   = bus.value;
          err_n   = bus.error;
          state_n = CHECK;
        end
      end

      CHECK: begin
        if (err_q) begin
          c2_n    = CH_E;
          c1_n    = CH_R;
          c0_n    = CH_R;
          en_n    = 4'b0111;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (val_ext > MAX_VAL || val_ext < MIN_VAL) begin
          c1_n    = CH_O;
          c0_n    = CH_F;
          en_n    = 4'b0011;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          neg_n   = val_q[WIDTH-1];
          mag_n   = abs_val;
          d3_n    = '0;
          d2_n    = '0;
          d1_n    = '0;
          place_n = 2'd0;
          state_n = SUB;
        end
      end

      SUB: begin
        case (place_q)
          2'd0: begin
            if (mag_q >= WIDTH'(1000)) begin
              mag_n = mag_q - WIDTH'(1000);
              d3_n  = d3_q + 4'd1;
            end else begin
              place_n = 2'd1;
            end
          end
          2'd1: begin
            if (mag_q >= WIDTH'(100)) begin
              mag_n = mag_q - WIDTH'(100);
              d2_n  = d2_q + 4'd1;
            end else begin
              place_n = 2'd2;
            end
          end
          default: begin
            if (mag_q >= WIDTH'(10)) begin
              mag_n = mag_q - WIDTH'(10);
              d1_n  = d1_q + 4'd1;
            end else begin
              // Remaining magnitude is the units digit; blank above digit k
              // and put the minus sign just left of it.
              c0_n = {1'b0, mag_q[3:0]};
              case (k)
                2'd3: begin
                  c3_n = {1'b0, d3_q};
                  c2_n = {1'b0, d2_q};
                  c1_n = {1'b0, d1_q};
                  en_n = 4'b1111;
                end
                2'd2: begin
                  c2_n = {1'b0, d2_q};
                  c1_n = {1'b0, d1_q};
                  en_n = 4'b0111;
                  if (neg_q) begin
                    c3_n = CH_MINUS;
                    en_n = 4'b1111;
                  end
                end
                2'd1: begin
                  c1_n = {1'b0, d1_q};
                  en_n = 4'b0011;
                  if (neg_q) begin
                    c2_n = CH_MINUS;
                    en_n = 4'b0111;
                  end
                end
                default: begin
                  en_n = 4'b0001;
                  if (neg_q) begin
                    c1_n = CH_MINUS;
                    en_n = 4'b0011;
                  end
                end
              endcase
              done_n  = 1'b1;
              state_n = FORMAT;
            end
          end
        endcase
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.char3 = c3_q;
  assign bus.char2 = c2_q;
  assign bus.char1 = c1_q;
  assign bus.char0 = c0_q;
  assign bus.en    = en_q;
  assign bus.done  = done_q;
  assign bus.busy  = (state_q == CHECK) || (state_q == SUB);

endmodule

// File: tb/tb_result_display_sequencer.sv
// Scoreboard bench for result_display_sequencer: expected displays are queued
// when a load is accepted and compared when done pulses.
module tb_result_display_sequencer;

  localparam int WIDTH = 16;

  typedef struct {
    logic [4:0] c3, c2, c1, c0;
    logic [3:0] en;
    int         lat;
    int         accept;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   in_flight = 1'b0;
  exp_t sb[$];

  logic [4:0] mdisp[4];
  logic [3:0] men;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  result_display_sequencer_if #(.WIDTH(WIDTH)) bus();

  result_display_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_output(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference display model built from decimal division, tracking stale chars.
  function automatic exp_t model(int v, bit e, int acc);
    exp_t r;
    int   a;
    int   d[4];
    int   k;
    if (e) begin
      mdisp[2] = 5'd14; mdisp[1] = 5'd13; mdisp[0] = 5'd13;
      men = 4'b0111;
      r.lat = 2;
    end else if (v > 9999 || v < -999) begin
      mdisp[1] = 5'd12; mdisp[0] = 5'd10;
      men = 4'b0011;
      r.lat = 2;
    end else begin
      a = (v < 0) ? -v : v;
      d[3] = a / 1000;
      d[2] = (a / 100) % 10;
      d[1] = (a / 10) % 10;
      d[0] = a % 10;
      k = 0;
      for (int i = 1; i < 4; i++) if (d[i] != 0) k = i;
      for (int i = 0; i <= k; i++) mdisp[i] = 5'(d[i]);
      men = 4'((1 << (k + 1)) - 1);
      if (v < 0) begin
        mdisp[k+1] = 5'd11;
        men[k+1]   = 1'b1;
      end
      r.lat = d[3] + d[2] + d[1] + 5;
    end
    r.c3 = mdisp[3]; r.c2 = mdisp[2]; r.c1 = mdisp[1]; r.c0 = mdisp[0];
    r.en = men;
    r.accept = acc;
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
      in_flight = 1'b0;
      for (int i = 0; i < 4; i++) mdisp[i] = 5'd0;
      men = 4'b0001;
    end else begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          check_output("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check_output("char3", bus.char3, e.c3);
          check_output("char2", bus.char2, e.c2);
          check_output("char1", bus.char1, e.c1);
          check_output("char0", bus.char0, e.c0);
          check_output("en", bus.en, e.en);
          check_output("latency", cyc - e.accept + 1, e.lat);
          check_output("busy_at_done", bus.busy, 0);
        end
        in_flight = 1'b0;
      end else if (in_flight) begin
        check_output("busy_during", bus.busy, 1);
      end
      if (bus.load && !bus.busy) begin
        sb.push_back(model(int'($signed(bus.value)), bus.error, cyc + 1));
        in_flight = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(int v, bit e);
    bus.load  = 1'b1;
    bus.value = WIDTH'(v);
    bus.error = e;
    tick();
    bus.load  = 1'b0;
    bus.error = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 200 && !idle; i++) begin
      if (sb.size() == 0 && !in_flight) idle = 1'b1;
      else tick();
    end
    if (!idle) check_output("timeout", 1, 0);
  endtask

  task automatic check_reset_state(string tag);
    @(negedge clk);
    check_output({tag, "_busy"}, bus.busy, 0);
    check_output({tag, "_done"}, bus.done, 0);
    check_output({tag, "_en"}, bus.en, 4'b0001);
    check_output({tag, "_char0"}, bus.char0, 0);
  endtask

  int vals[11] = '{1234, -45, 0, -999, 10000, -1000, 7, 9999, -32768, 305, -7};
  bit errs[11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

  initial begin
    bus.load  = 1'b0;
    bus.value = '0;
    bus.error = 1'b0;
    reset     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_reset_state("rst");
    tick();

    // Reset in the middle of a conversion must discard it silently.
    apply_stimulus(5678, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("midrst");
    repeat (40) tick();

    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vals[i], errs[i]);
      wait_idle();
      tick();
    end

    // Held load: 9 is taken on the done cycle of 8; a later pulse is ignored.
    bus.load  = 1'b1;
    bus.value = WIDTH'(8);
    tick();
    bus.value = WIDTH'(9);
    repeat (5) tick();
    bus.load = 1'b0;
    repeat (2) tick();
    bus.load  = 1'b1;
    bus.value = WIDTH'(3);
    tick();
    bus.load = 1'b0;
    wait_idle();
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
